rs_issue_select: RTL and testbench

- Reservation-station occupancy and issue-select unit: the read/free side of the dispatch-stage entry allocator.
- Holds per-entry busy and operand-ready state, and accepts up to two allocation writes per cycle at allocator-chosen addresses.
- Snoops two result-tag wakeup buses and selects one ready entry per cycle to issue to the functional unit.
- Frees the issued entry and exports the busy vector back to the allocator. A mispredict flush clears the station.

---
 rtl/rs_issue_select_pkg.sv | 19 +
 rtl/rs_issue_select_if.sv | 61 ++++++
 rtl/rs_select_enc.sv | 33 +++
 rtl/rs_issue_select.sv | 143 ++++++++++++++
 tb/tb_rs_issue_select.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rs_issue_select_pkg.sv
// ============================================================================
// Module   : rs_issue_select_pkg
// Purpose  : Shared sizing constants for the reservation-station issue unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rs_issue_select_pkg;

    localparam int c_REQ_LEN   = 8;
    localparam int c_GRANT_LEN = 3;
    localparam int c_TAG_W     = 6;
    // Width of the RS entry-select index, kept distinct so the allocator can share it.
    localparam int c_SEL_W     = c_GRANT_LEN;
    localparam int c_CNT_W     = c_GRANT_LEN + 1;

endpackage : rs_issue_select_pkg

`default_nettype wire

// File: rtl/rs_issue_select_if.sv
// ============================================================================
// Module   : rs_issue_select_if
// Purpose  : Dispatch-write, wakeup, issue and busy-export signals of the RS.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rs_issue_select_if
    import rs_issue_select_pkg::*;
#(
    parameter int REQ_LEN   = c_REQ_LEN,
    parameter int GRANT_LEN = c_GRANT_LEN,
    parameter int TAG_W     = c_TAG_W
);

    logic                 we1;
    logic [GRANT_LEN-1:0] waddr1;
    logic [TAG_W-1:0]     wtag1_a;
    logic [TAG_W-1:0]     wtag1_b;
    logic                 wrdy1_a;
    logic                 wrdy1_b;

    logic                 we2;
    logic [GRANT_LEN-1:0] waddr2;
    logic [TAG_W-1:0]     wtag2_a;
    logic [TAG_W-1:0]     wtag2_b;
    logic                 wrdy2_a;
    logic                 wrdy2_b;

    logic                 wk_en0;
    logic                 wk_en1;
    logic [TAG_W-1:0]     wk_tag0;
    logic [TAG_W-1:0]     wk_tag1;

    logic                 fu_stall;
    logic                 prmiss;

    logic [REQ_LEN-1:0]   busy;
    logic                 issue_valid;
    logic [GRANT_LEN-1:0] issue_addr;
    logic [GRANT_LEN:0]   ready_cnt;

    modport master (
        output we1, waddr1, wtag1_a, wtag1_b, wrdy1_a, wrdy1_b,
        output we2, waddr2, wtag2_a, wtag2_b, wrdy2_a, wrdy2_b,
        output wk_en0, wk_en1, wk_tag0, wk_tag1,
        output fu_stall, prmiss,
        input  busy, issue_valid, issue_addr, ready_cnt
    );

    modport slave (
        input  we1, waddr1, wtag1_a, wtag1_b, wrdy1_a, wrdy1_b,
        input  we2, waddr2, wtag2_a, wtag2_b, wrdy2_a, wrdy2_b,
        input  wk_en0, wk_en1, wk_tag0, wk_tag1,
        input  fu_stall, prmiss,
        output busy, issue_valid, issue_addr, ready_cnt
    );

endinterface : rs_issue_select_if

`default_nettype wire

// File: rtl/rs_select_enc.sv
// ============================================================================
// Module   : rs_select_enc
// Purpose  : Lowest-index priority encoder over the eligible-entry vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_select_enc
    import rs_issue_select_pkg::*;
#(
    parameter int REQ_LEN   = c_REQ_LEN,
    parameter int GRANT_LEN = c_GRANT_LEN
) (
    input  logic [REQ_LEN-1:0]   req,
    output logic [GRANT_LEN-1:0] grant_idx,
    output logic                 grant_valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = REQ_LEN - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx   = GRANT_LEN'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule : rs_select_enc

`default_nettype wire

// File: rtl/rs_issue_select.sv
// ============================================================================
// Module   : rs_issue_select
// Purpose  : RS occupancy, operand wakeup and single-issue select with flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int REQ_LEN   = c_REQ_LEN,
    parameter int GRANT_LEN = c_GRANT_LEN,
    parameter int TAG_W     = c_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    rs_issue_select_if.slave bus
);

    logic [REQ_LEN-1:0]   w_busy;
    logic [REQ_LEN-1:0]   w_elig;
    logic [GRANT_LEN-1:0] w_sel_idx;
    logic                 w_sel_valid;
    logic                 w_issue_fire;
    logic [GRANT_LEN:0]   w_ready_cnt;

    function automatic logic tag_hit(
        input logic [TAG_W-1:0] tag,
        input logic             en0,
        input logic [TAG_W-1:0] tag0,
        input logic             en1,
        input logic [TAG_W-1:0] tag1
    );
        return (en0 && (tag == tag0)) || (en1 && (tag == tag1));
    endfunction

    assign w_issue_fire = w_sel_valid & ~bus.fu_stall;

    for (genvar i = 0; i < REQ_LEN; i++) begin : g_entry
        logic             r_busy;
        logic             r_rdy_a;
        logic             r_rdy_b;
        logic [TAG_W-1:0] r_tag_a;
        logic [TAG_W-1:0] r_tag_b;
        logic             w_wsel1;
        logic             w_wsel2;
        logic             w_wk_a;
        logic             w_wk_b;
        logic             w_issue_here;

        // Port 2 wins a same-address collision, so port 1 is masked by it.
        assign w_wsel2      = bus.we2 && (bus.waddr2 == GRANT_LEN'(i));
        assign w_wsel1      = bus.we1 && (bus.waddr1 == GRANT_LEN'(i)) && !w_wsel2;
        assign w_wk_a       = tag_hit(r_tag_a, bus.wk_en0, bus.wk_tag0, bus.wk_en1, bus.wk_tag1);
        assign w_wk_b       = tag_hit(r_tag_b, bus.wk_en0, bus.wk_tag0, bus.wk_en1, bus.wk_tag1);
        assign w_issue_here = w_issue_fire && (w_sel_idx == GRANT_LEN'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_busy  <= 1'b0;
                r_rdy_a <= 1'b0;
                r_rdy_b <= 1'b0;
                r_tag_a <= '0;
                r_tag_b <= '0;
            end else if (bus.prmiss) begin
                r_busy <= 1'b0;
            end else if (w_wsel2) begin
                r_busy  <= 1'b1;
                r_tag_a <= bus.wtag2_a;
                r_tag_b <= bus.wtag2_b;
                r_rdy_a <= bus.wrdy2_a | tag_hit(bus.wtag2_a, bus.wk_en0, bus.wk_tag0,
                                                 bus.wk_en1, bus.wk_tag1);
                r_rdy_b <= bus.wrdy2_b | tag_hit(bus.wtag2_b, bus.wk_en0, bus.wk_tag0,
                                                 bus.wk_en1, bus.wk_tag1);
            end else if (w_wsel1) begin
                r_busy  <= 1'b1;
                r_tag_a <= bus.wtag1_a;
                r_tag_b <= bus.wtag1_b;
                r_rdy_a <= bus.wrdy1_a | tag_hit(bus.wtag1_a, bus.wk_en0, bus.wk_tag0,
                                                 bus.wk_en1, bus.wk_tag1);
                r_rdy_b <= bus.wrdy1_b | tag_hit(bus.wtag1_b, bus.wk_en0, bus.wk_tag0,
                                                 bus.wk_en1, bus.wk_tag1);
            end else begin
                if (w_issue_here) begin
                    r_busy <= 1'b0;
                end
                if (r_busy && !r_rdy_a && w_wk_a) begin
                    r_rdy_a <= 1'b1;
                end
                if (r_busy && !r_rdy_b && w_wk_b) begin
                    r_rdy_b <= 1'b1;
                end
            end
        end

        assign w_busy[i] = r_busy;
        assign w_elig[i] = r_busy & r_rdy_a & r_rdy_b;
    end : g_entry

    rs_select_enc #(
        .REQ_LEN   (REQ_LEN),
        .GRANT_LEN (GRANT_LEN)
    ) u_select (
        .req         (w_elig),
        .grant_idx   (w_sel_idx),
        .grant_valid (w_sel_valid)
    );

    // One extra bit so a fully eligible station counts to REQ_LEN without wrapping.
    always_comb begin
        w_ready_cnt = '0;
        for (int k = 0; k < REQ_LEN; k++) begin
            w_ready_cnt = w_ready_cnt + (GRANT_LEN + 1)'(w_elig[k]);
        end
    end

    assign bus.busy        = w_busy;
    assign bus.issue_valid = w_sel_valid;
    assign bus.issue_addr  = w_sel_idx;
    assign bus.ready_cnt   = w_ready_cnt;

`ifndef SYNTHESIS
    a_dual_write_same_addr : assert property (
        @(posedge clk) disable iff (reset)
        !(bus.we1 && bus.we2 && (bus.waddr1 == bus.waddr2) && !bus.prmiss)
    ) else $error("rs_issue_select: we1 and we2 target the same entry");

    a_write1_busy : assert property (
        @(posedge clk) disable iff (reset)
        (bus.we1 && !bus.prmiss) |->
            (!w_busy[bus.waddr1] || (w_issue_fire && (w_sel_idx == bus.waddr1)))
    ) else $error("rs_issue_select: port 1 writes a busy, non-issuing entry");

    a_write2_busy : assert property (
        @(posedge clk) disable iff (reset)
        (bus.we2 && !bus.prmiss) |->
            (!w_busy[bus.waddr2] || (w_issue_fire && (w_sel_idx == bus.waddr2)))
    ) else $error("rs_issue_select: port 2 writes a busy, non-issuing entry");
`endif

endmodule : rs_issue_select

`default_nettype wire

// File: tb/tb_rs_issue_select.sv
// ============================================================================
// Module   : tb_rs_issue_select
// Purpose  : Scenario bench for rs_issue_select with an issue-order scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rs_issue_select;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_q[$];

    rs_issue_select_if bus ();

    rs_issue_select dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted issue must match the next entry the scenarios predicted.
    always @(negedge clk) begin
        if (!reset && !bus.prmiss && bus.issue_valid && !bus.fu_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue got addr %0d with no expected entry",
                         bus.issue_addr);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(bus.issue_addr) !== e) begin
                    errors++;
                    $display("FAIL sb_issue_addr got %0d exp %0d", bus.issue_addr, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        bus.we1 = 1'b0; bus.waddr1 = '0; bus.wtag1_a = '0; bus.wtag1_b = '0;
        bus.wrdy1_a = 1'b0; bus.wrdy1_b = 1'b0;
        bus.we2 = 1'b0; bus.waddr2 = '0; bus.wtag2_a = '0; bus.wtag2_b = '0;
        bus.wrdy2_a = 1'b0; bus.wrdy2_b = 1'b0;
        bus.wk_en0 = 1'b0; bus.wk_en1 = 1'b0; bus.wk_tag0 = '0; bus.wk_tag1 = '0;
    endtask

    task automatic alloc1(input int a, input int ta, input int tb, input bit ra, input bit rb);
        bus.we1 = 1'b1; bus.waddr1 = 3'(a); bus.wtag1_a = 6'(ta); bus.wtag1_b = 6'(tb);
        bus.wrdy1_a = ra; bus.wrdy1_b = rb;
    endtask

    task automatic alloc2(input int a, input int ta, input int tb, input bit ra, input bit rb);
        bus.we2 = 1'b1; bus.waddr2 = 3'(a); bus.wtag2_a = 6'(ta); bus.wtag2_b = 6'(tb);
        bus.wrdy2_a = ra; bus.wrdy2_b = rb;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_writes();
        bus.fu_stall = 1'b0;
        bus.prmiss   = 1'b0;
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_issue_valid", int'(bus.issue_valid), 0);
        chk("reset_issue_addr", int'(bus.issue_addr), 0);
        chk("reset_ready_cnt", int'(bus.ready_cnt), 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_issue();
        alloc1(3, 1, 2, 1'b1, 1'b1);
        exp_q.push_back(3);
        tick();
        clear_writes();
        chk("single_busy", int'(bus.busy), 'h08);
        chk("single_valid", int'(bus.issue_valid), 1);
        chk("single_addr", int'(bus.issue_addr), 3);
        chk("single_cnt", int'(bus.ready_cnt), 1);
        tick();
        chk("single_busy_after", int'(bus.busy), 'h00);
        chk("single_valid_after", int'(bus.issue_valid), 0);
    endtask

    task automatic test_wakeup_order();
        bus.fu_stall = 1'b1;
        alloc1(1, 7, 9, 1'b0, 1'b0);
        alloc2(5, 7, 7, 1'b0, 1'b0);
        tick();
        clear_writes();
        chk("wk_busy", int'(bus.busy), 'h22);
        chk("wk_valid_none", int'(bus.issue_valid), 0);
        chk("wk_cnt0", int'(bus.ready_cnt), 0);
        bus.wk_en0 = 1'b1; bus.wk_tag0 = 6'd7;
        tick();
        bus.wk_en0 = 1'b0;
        chk("wk_cnt1", int'(bus.ready_cnt), 1);
        chk("wk_addr5", int'(bus.issue_addr), 5);
        bus.wk_en1 = 1'b1; bus.wk_tag1 = 6'd9;
        tick();
        bus.wk_en1 = 1'b0;
        chk("wk_cnt2", int'(bus.ready_cnt), 2);
        chk("wk_addr1", int'(bus.issue_addr), 1);
        exp_q.push_back(1);
        exp_q.push_back(5);
        bus.fu_stall = 1'b0;
        tick();
        chk("wk_busy_after1", int'(bus.busy), 'h20);
        chk("wk_addr5_next", int'(bus.issue_addr), 5);
        tick();
        chk("wk_busy_empty", int'(bus.busy), 'h00);
    endtask

    task automatic test_bypass();
        alloc1(2, 4, 11, 1'b0, 1'b1);
        bus.wk_en1 = 1'b1; bus.wk_tag1 = 6'd4;
        exp_q.push_back(2);
        tick();
        clear_writes();
        chk("bypass_valid", int'(bus.issue_valid), 1);
        chk("bypass_addr", int'(bus.issue_addr), 2);
        tick();
        chk("bypass_busy_after", int'(bus.busy), 'h00);
    endtask

    task automatic test_stall();
        bus.fu_stall = 1'b1;
        alloc1(0, 3, 5, 1'b1, 1'b1);
        tick();
        clear_writes();
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", int'(bus.issue_addr), 0);
            chk("stall_busy0", int'(bus.busy[0]), 1);
            tick();
        end
        chk("stall_busy0_end", int'(bus.busy[0]), 1);
        exp_q.push_back(0);
        bus.fu_stall = 1'b0;
        tick();
        chk("stall_released_busy", int'(bus.busy), 'h00);
    endtask

    task automatic fill_all(input bit all_ready);
        for (int p = 0; p < 4; p++) begin
            int a0;
            int a1;
            a0 = 2 * p;
            a1 = 2 * p + 1;
            alloc1(a0, 20 + a0, 40 + a0, all_ready || a0 == 0 || a0 == 2 || a0 == 6, 1'b1);
            alloc2(a1, 20 + a1, 40 + a1, all_ready, 1'b1);
            tick();
            clear_writes();
        end
    endtask

    task automatic test_flush();
        bus.fu_stall = 1'b1;
        fill_all(1'b0);
        chk("flush_full", int'(bus.busy), 'hFF);
        chk("flush_cnt", int'(bus.ready_cnt), 3);
        chk("flush_sel", int'(bus.issue_addr), 0);
        bus.fu_stall = 1'b0;
        bus.prmiss   = 1'b1;
        alloc1(4, 1, 1, 1'b1, 1'b1);
        tick();
        clear_writes();
        bus.prmiss = 1'b0;
        chk("flush_busy", int'(bus.busy), 'h00);
        chk("flush_valid", int'(bus.issue_valid), 0);
        chk("flush_cnt_after", int'(bus.ready_cnt), 0);
    endtask

    task automatic test_async_reset();
        bus.fu_stall = 1'b1;
        fill_all(1'b1);
        chk("areset_full", int'(bus.busy), 'hFF);
        chk("areset_cnt_full", int'(bus.ready_cnt), 8);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_busy", int'(bus.busy), 'h00);
        chk("areset_valid", int'(bus.issue_valid), 0);
        chk("areset_cnt", int'(bus.ready_cnt), 0);
        tick();
        reset = 1'b0;
        bus.fu_stall = 1'b0;
        tick();
        chk("areset_still_empty", int'(bus.busy), 'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_issue();
        test_wakeup_order();
        test_bypass();
        test_stall();
        test_flush();
        test_async_reset();
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_rs_issue_select

`default_nettype wire
